// File: rtl/ppc_hazard_scoreboard.sv
// Hazard/bypass scoreboard: tracks in-flight GPR writers over NSTG post-decode stages.
// Optional stall performance counter enabled by defining SCB_PERF_CNT_EN.
module ppc_hazard_scoreboard #(
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 3,
  parameter int unsigned NSTG = 3,
  parameter int unsigned SELW = $clog2(NSTG + 1),
  parameter int unsigned RW   = $clog2(NSTG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid_i,
  input  logic [NRD*AW-1:0]   id_rr_i,
  input  logic [NRD-1:0]      id_ruse_i,
  input  logic                id_we_i,
  input  logic [AW-1:0]       id_wr_i,
  input  logic [RW-1:0]       id_rdy_i,
  input  logic                ext_stall_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                issue_o,
  output logic [NRD*SELW-1:0] byp_sel_o,
  output logic [SELW-1:0]     occ_o,
  output logic [31:0]         stall_cnt_o
);

  logic [NSTG-1:0] v_q, v_d;
  logic [NSTG-1:0] we_q, we_d;
  logic [AW-1:0]   wr_q  [NSTG];
  logic [AW-1:0]   wr_d  [NSTG];
  logic [RW-1:0]   rdy_q [NSTG];
  logic [RW-1:0]   rdy_d [NSTG];
  logic [SELW-1:0] occ_q, occ_d;
  logic [NRD-1:0]  hazard;
  logic [RW-1:0]   rdy_clamp;

  // Out-of-range ready stages degrade to "forward from the final entry only".
  assign rdy_clamp = (32'(id_rdy_i) >= NSTG) ? RW'(NSTG - 1) : id_rdy_i;

  always_comb begin
    byp_sel_o = '0;
    hazard    = '0;
    for (int p = 0; p < NRD; p++) begin
      // Walk oldest to youngest so the youngest match overwrites.
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (id_ruse_i[p] && v_q[k] && we_q[k] && (wr_q[k] == id_rr_i[p*AW +: AW])) begin
          if (int'(rdy_q[k]) <= k) begin
            byp_sel_o[p*SELW +: SELW] = SELW'(k + 1);
            hazard[p]                 = 1'b0;
          end else begin
            byp_sel_o[p*SELW +: SELW] = '0;
            hazard[p]                 = 1'b1;
          end
        end
      end
    end
  end

  assign stall_o = id_valid_i & (|hazard);
  assign issue_o = id_valid_i & ~stall_o & ~ext_stall_i & ~flush_i;

  always_comb begin
    v_d   = v_q;
    we_d  = we_q;
    wr_d  = wr_q;
    rdy_d = rdy_q;
    if (!ext_stall_i) begin
      for (int k = 1; k < NSTG; k++) begin
        v_d[k]   = v_q[k-1];
        we_d[k]  = we_q[k-1];
        wr_d[k]  = wr_q[k-1];
        rdy_d[k] = rdy_q[k-1];
      end
      v_d[0]   = issue_o;
      we_d[0]  = id_we_i;
      wr_d[0]  = id_wr_i;
      rdy_d[0] = rdy_clamp;
    end
    if (flush_i) begin
      v_d[0] = 1'b0;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < NSTG; k++) begin
      occ_d = occ_d + SELW'(v_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q   <= '0;
      we_q  <= '0;
      occ_q <= '0;
      for (int k = 0; k < NSTG; k++) begin
        wr_q[k]  <= '0;
        rdy_q[k] <= '0;
      end
    end else begin
      v_q   <= v_d;
      we_q  <= we_d;
      occ_q <= occ_d;
      for (int k = 0; k < NSTG; k++) begin
        wr_q[k]  <= wr_d[k];
        rdy_q[k] <= rdy_d[k];
      end
    end
  end

  assign occ_o = occ_q;

`ifdef SCB_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts only hazard stalls, not cycles frozen by the external stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall_o && !ext_stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_ppc_hazard_scoreboard.sv
// Directed self-checking bench for ppc_hazard_scoreboard (default parameters).
module tb_ppc_hazard_scoreboard;

  localparam int AW   = 5;
  localparam int NRD  = 3;
  localparam int SELW = 2;
  localparam int RW   = 2;
`ifdef SCB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid_i;
  logic [NRD*AW-1:0]   id_rr_i;
  logic [NRD-1:0]      id_ruse_i;
  logic                id_we_i;
  logic [AW-1:0]       id_wr_i;
  logic [RW-1:0]       id_rdy_i;
  logic                ext_stall_i;
  logic                flush_i;
  logic                stall_o;
  logic                issue_o;
  logic [NRD*SELW-1:0] byp_sel_o;
  logic [SELW-1:0]     occ_o;
  logic [31:0]         stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppc_hazard_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid_i  (id_valid_i),
    .id_rr_i     (id_rr_i),
    .id_ruse_i   (id_ruse_i),
    .id_we_i     (id_we_i),
    .id_wr_i     (id_wr_i),
    .id_rdy_i    (id_rdy_i),
    .ext_stall_i (ext_stall_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .issue_o     (issue_o),
    .byp_sel_o   (byp_sel_o),
    .occ_o       (occ_o),
    .stall_cnt_o (stall_cnt_o)
  );

  task automatic drive(input logic valid, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic [AW-1:0] r2, input logic [2:0] ruse, input logic we,
                       input logic [AW-1:0] wr, input logic [RW-1:0] rdy, input logic ext,
                       input logic fl);
    id_valid_i  = valid;
    id_rr_i     = {r2, r1, r0};
    id_ruse_i   = ruse;
    id_we_i     = we;
    id_wr_i     = wr;
    id_rdy_i    = rdy;
    ext_stall_i = ext;
    flush_i     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  // Leaves the bench at a negedge with reset applied on the preceding posedge.
  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue a producer with no reads, advance one cycle.
  task automatic produce(input logic [AW-1:0] wr, input logic [RW-1:0] rdy);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, wr, rdy, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    idle();
    #1;
    checks++;
    if (stall_o !== 1'b0 || issue_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: stall=%b issue=%b want 0 0", stall_o, issue_o);
    end
    checks++;
    if (byp_sel_o !== 6'd0 || occ_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: sel=%b occ=%0d want 0 0", byp_sel_o, occ_o);
    end
    checks++;
    if (stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d want 0", stall_cnt_o);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    produce(5'd5, 2'd0);
    drive(1'b1, 5'd0, 5'd5, 5'd0, 3'b010, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall_o !== 1'b0 || issue_o !== 1'b1 || byp_sel_o !== 6'b000100) begin
      errors++;
      $display("FAIL b2b_alu: stall=%b issue=%b sel=%b want 0 1 000100",
               stall_o, issue_o, byp_sel_o);
    end
    @(negedge clk);
    idle();
    #1;
    checks++;
    if (occ_o !== 2'd2) begin
      errors++;
      $display("FAIL b2b_occ: got %0d want 2", occ_o);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    do_reset();
    produce(5'd7, 2'd1);
    drive(1'b1, 5'd7, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall_o !== 1'b1 || issue_o !== 1'b0) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b issue=%b want 1 0", stall_o, issue_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall_o !== 1'b0 || issue_o !== 1'b1 || byp_sel_o !== 6'b000010) begin
      errors++;
      $display("FAIL load_use_fwd: stall=%b issue=%b sel=%b want 0 1 000010",
               stall_o, issue_o, byp_sel_o);
    end
    checks++;
    if (stall_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin
      errors++;
      $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt_o, PERF ? 1 : 0);
    end
    @(negedge clk);
  endtask

  task automatic test_youngest();
    do_reset();
    produce(5'd3, 2'd0);
    produce(5'd8, 2'd0);
    produce(5'd3, 2'd0);
    drive(1'b1, 5'd0, 5'd0, 5'd3, 3'b100, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (byp_sel_o !== 6'b010000 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL youngest_sel: sel=%b stall=%b want 010000 0", byp_sel_o, stall_o);
    end
    checks++;
    if (occ_o !== 2'd3) begin
      errors++;
      $display("FAIL youngest_occ: got %0d want 3", occ_o);
    end
    @(negedge clk);
  endtask

  task automatic test_retire();
    do_reset();
    produce(5'd10, 2'd0);
    idle();
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 5'd10, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (byp_sel_o !== 6'b000011 || occ_o !== 2'd1) begin
      errors++;
      $display("FAIL retire_final: sel=%b occ=%0d want 000011 1", byp_sel_o, occ_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (byp_sel_o !== 6'b000000 || occ_o !== 2'd0) begin
      errors++;
      $display("FAIL retire_gone: sel=%b occ=%0d want 000000 0", byp_sel_o, occ_o);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal_rdy();
    do_reset();
    produce(5'd11, 2'd3);
    drive(1'b1, 5'd11, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_rdy_e0: stall=%b want 1", stall_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_rdy_e1: stall=%b want 1", stall_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (stall_o !== 1'b0 || issue_o !== 1'b1 || byp_sel_o !== 6'b000011) begin
      errors++;
      $display("FAIL illegal_rdy_e2: stall=%b issue=%b sel=%b want 0 1 000011",
               stall_o, issue_o, byp_sel_o);
    end
    checks++;
    if (stall_cnt_o !== (PERF ? 32'd2 : 32'd0)) begin
      errors++;
      $display("FAIL illegal_rdy_cnt: got %0d want %0d", stall_cnt_o, PERF ? 2 : 0);
    end
    @(negedge clk);
  endtask

  task automatic test_freeze_flush();
    do_reset();
    produce(5'd4, 2'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd4, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
      #1;
      checks++;
      if (stall_o !== 1'b1 || issue_o !== 1'b0 || occ_o !== 2'd1) begin
        errors++;
        $display("FAIL freeze_%0d: stall=%b issue=%b occ=%0d want 1 0 1",
                 i, stall_o, issue_o, occ_o);
      end
      @(negedge clk);
    end
    checks++;
    if (stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL freeze_cnt: got %0d want 0", stall_cnt_o);
    end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 5'd6, 2'd0, 1'b0, 1'b1);
    #1;
    checks++;
    if (issue_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_issue: got %b want 0", issue_o);
    end
    @(negedge clk);
    drive(1'b1, 5'd4, 5'd6, 5'd0, 3'b011, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (occ_o !== 2'd1 || byp_sel_o !== 6'b000010 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_after: occ=%0d sel=%b stall=%b want 1 000010 0",
               occ_o, byp_sel_o, stall_o);
    end
    @(negedge clk);
    // Flush during freeze must still empty entry 0.
    do_reset();
    produce(5'd12, 2'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 5'd12, 5'd0, 5'd0, 3'b001, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
    #1;
    checks++;
    if (occ_o !== 2'd0 || byp_sel_o !== 6'b000000) begin
      errors++;
      $display("FAIL flush_frozen: occ=%0d sel=%b want 0 000000", occ_o, byp_sel_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    produce(5'd1, 2'd1);
    produce(5'd2, 2'd0);
    produce(5'd3, 2'd1);
    idle();
    ext_stall_i = 1'b1;
    #1;
    checks++;
    if (occ_o !== 2'd3) begin
      errors++;
      $display("FAIL mid_pre_occ: got %0d want 3", occ_o);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 3'b111, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    #1;
    checks++;
    if (occ_o !== 2'd0 || byp_sel_o !== 6'b000000 || stall_o !== 1'b0 || issue_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: occ=%0d sel=%b stall=%b issue=%b want 0 000000 0 1",
               occ_o, byp_sel_o, stall_o, issue_o);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_youngest();
    test_retire();
    test_illegal_rdy();
    test_freeze_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
